// File: rtl/jtag_tap_pkg.sv
// jtag_tap_pkg: shared TAP state encoding, next-state function and default
// opcodes for the oversampled JTAG TAP (jtag_tap_core).
package jtag_tap_pkg;

  // IEEE 1149.1 state encoding, as seen on tap_state
  typedef enum logic [3:0] {
    TLR      = 4'hF,
    RTI      = 4'hC,
    SEL_DR   = 4'h7,
    CAP_DR   = 4'h6,
    SH_DR    = 4'h2,
    EX1_DR   = 4'h1,
    PAUSE_DR = 4'h3,
    EX2_DR   = 4'h0,
    UPD_DR   = 4'h5,
    SEL_IR   = 4'h4,
    CAP_IR   = 4'hE,
    SH_IR    = 4'hA,
    EX1_IR   = 4'h9,
    PAUSE_IR = 4'hB,
    EX2_IR   = 4'h8,
    UPD_IR   = 4'hD
  } tap_state_e;

  localparam logic [31:0] DEF_IDCODE_VAL   = 32'h1000_563D;
  localparam logic [3:0]  DEF_IDCODE_INSTR = 4'h1;
  localparam logic [3:0]  DEF_BYPASS_INSTR = 4'hF;
  localparam logic [3:0]  DEF_USER_INSTR   = 4'h8;

  // Standard TAP transition taken on a tck rise
  function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
    tap_state_e n;
    n = TLR;
    case (s)
      TLR:      n = tms ? TLR    : RTI;
      RTI:      n = tms ? SEL_DR : RTI;
      SEL_DR:   n = tms ? SEL_IR : CAP_DR;
      CAP_DR:   n = tms ? EX1_DR : SH_DR;
      SH_DR:    n = tms ? EX1_DR : SH_DR;
      EX1_DR:   n = tms ? UPD_DR : PAUSE_DR;
      PAUSE_DR: n = tms ? EX2_DR : PAUSE_DR;
      EX2_DR:   n = tms ? UPD_DR : SH_DR;
      UPD_DR:   n = tms ? SEL_DR : RTI;
      SEL_IR:   n = tms ? TLR    : CAP_IR;
      CAP_IR:   n = tms ? EX1_IR : SH_IR;
      SH_IR:    n = tms ? EX1_IR : SH_IR;
      EX1_IR:   n = tms ? UPD_IR : PAUSE_IR;
      PAUSE_IR: n = tms ? EX2_IR : PAUSE_IR;
      EX2_IR:   n = tms ? UPD_IR : SH_IR;
      UPD_IR:   n = tms ? SEL_DR : RTI;
      default:  n = TLR;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/jtag_tck_edge.sv
// jtag_tck_edge: synchronises tck/tms/tdi into sys_clk and flags tck edges.
// tms/tdi come from the same stage as tck so they line up with the edge.
module jtag_tck_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic tck,
  input  logic tms,
  input  logic tdi,
  output logic tck_rise,
  output logic tck_fall,
  output logic tms_s,
  output logic tdi_s
);

  logic [SYNC_STAGES-1:0] tck_sync;
  logic [SYNC_STAGES-1:0] tms_sync;
  logic [SYNC_STAGES-1:0] tdi_sync;
  logic                   tck_d;

  // Shift the pins through the synchroniser chain and keep the last synced tck
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tck_sync <= '0;
      tms_sync <= '0;
      tdi_sync <= '0;
      tck_d    <= 1'b0;
    end else begin
      tck_sync[0] <= tck;
      tms_sync[0] <= tms;
      tdi_sync[0] <= tdi;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        tck_sync[i] <= tck_sync[i-1];
        tms_sync[i] <= tms_sync[i-1];
        tdi_sync[i] <= tdi_sync[i-1];
      end
      tck_d <= tck_sync[SYNC_STAGES-1];
    end
  end

  assign tck_rise = tck_sync[SYNC_STAGES-1] & ~tck_d;
  assign tck_fall = ~tck_sync[SYNC_STAGES-1] & tck_d;
  assign tms_s    = tms_sync[SYNC_STAGES-1];
  assign tdi_s    = tdi_sync[SYNC_STAGES-1];

endmodule

// File: rtl/jtag_tap_core.sv
// jtag_tap_core: IEEE 1149.1 TAP running in sys_clk by oversampling tck.
// Provides IR, IDCODE and BYPASS. Defining JTAG_TAP_USER_DR_EN adds a 32-bit
// user data register (user_din/user_dout/user_update) selected by USER_INSTR.
module jtag_tap_core
  import jtag_tap_pkg::*;
#(
  parameter int                IR_LEN       = 4,
  parameter logic [31:0]       IDCODE_VAL   = DEF_IDCODE_VAL,
  parameter logic [IR_LEN-1:0] IDCODE_INSTR = IR_LEN'(DEF_IDCODE_INSTR),
  parameter logic [IR_LEN-1:0] BYPASS_INSTR = IR_LEN'(DEF_BYPASS_INSTR),
  parameter int                SYNC_STAGES  = 2
`ifdef JTAG_TAP_USER_DR_EN
  , parameter logic [IR_LEN-1:0] USER_INSTR = IR_LEN'(DEF_USER_INSTR)
`endif
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              tck,
  input  logic              tms,
  input  logic              tdi,
  output logic              tdo,
  output logic [3:0]        tap_state,
  output logic [IR_LEN-1:0] ir_out,
  output logic              tlr_active
`ifdef JTAG_TAP_USER_DR_EN
  , input  logic [31:0]     user_din
  , output logic [31:0]     user_dout
  , output logic            user_update
`endif
);

  logic              tck_rise;
  logic              tck_fall;
  logic              tms_s;
  logic              tdi_s;
  tap_state_e        state;
  tap_state_e        state_nxt;
  logic [IR_LEN-1:0] ir_shift;
  logic [31:0]       dr_shift;
  logic              bypass_sr;
  logic              sel_idcode;
  logic              sel_user;
  logic              sel_bypass;

  jtag_tck_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .tck      (tck),
    .tms      (tms),
    .tdi      (tdi),
    .tck_rise (tck_rise),
    .tck_fall (tck_fall),
    .tms_s    (tms_s),
    .tdi_s    (tdi_s)
  );

  assign state_nxt  = tap_next(state, tms_s);
  assign tap_state  = state;
  assign tlr_active = (state == TLR);

  // Instruction decode; anything unrecognised falls back to BYPASS
  assign sel_idcode = (ir_out == IDCODE_INSTR);
`ifdef JTAG_TAP_USER_DR_EN
  assign sel_user   = (ir_out == USER_INSTR) && !sel_idcode;
`else
  assign sel_user   = 1'b0;
`endif
  assign sel_bypass = (ir_out == BYPASS_INSTR) || !(sel_idcode || sel_user);

  // TAP FSM with IR/DR actions on tck rise and tdo update on tck fall
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= TLR;
      ir_shift  <= '0;
      ir_out    <= IDCODE_INSTR;
      dr_shift  <= '0;
      bypass_sr <= 1'b0;
      tdo       <= 1'b0;
`ifdef JTAG_TAP_USER_DR_EN
      user_dout   <= '0;
      user_update <= 1'b0;
`endif
    end else begin
`ifdef JTAG_TAP_USER_DR_EN
      user_update <= 1'b0;
`endif
      if (tck_rise) begin
        state <= state_nxt;
        case (state)
          CAP_IR: ir_shift <= IR_LEN'(2'b01);
          SH_IR:  ir_shift <= {tdi_s, ir_shift[IR_LEN-1:1]};
          UPD_IR: ir_out   <= ir_shift;
          CAP_DR: begin
            if (sel_idcode) begin
              dr_shift <= IDCODE_VAL;
`ifdef JTAG_TAP_USER_DR_EN
            end else if (sel_user) begin
              dr_shift <= user_din;
`endif
            end else begin
              bypass_sr <= 1'b0;
            end
          end
          SH_DR: begin
            if (sel_bypass) bypass_sr <= tdi_s;
            else            dr_shift  <= {tdi_s, dr_shift[31:1]};
          end
`ifdef JTAG_TAP_USER_DR_EN
          UPD_DR: begin
            if (sel_user) begin
              user_dout   <= dr_shift;
              user_update <= 1'b1;
            end
          end
`endif
          default: ;
        endcase
        // IR returns to IDCODE on entry to TLR and is held there while in it
        if (state == TLR || state_nxt == TLR) ir_out <= IDCODE_INSTR;
      end else if (tck_fall) begin
        if (state == SH_IR)      tdo <= ir_shift[0];
        else if (state == SH_DR) tdo <= sel_bypass ? bypass_sr : dr_shift[0];
        else                     tdo <= 1'b0;
      end
    end
  end

endmodule

// File: doc/jtag_tap_core.md
Name: jtag_tap_core

Overview:
- Downstream of the DPI JTAG bit-bang driver.
- Consumes tck/tms/tdi (driven synchronously to sys_clk) and returns tdo.
- Implements an IEEE 1149.1 TAP in the sys_clk domain by oversampling tck: 16-state TAP FSM, instruction register, IDCODE and BYPASS data registers.
- Gives simulation and FPGA targets a debuggable JTAG endpoint without a real tck clock domain.

Parameters:
- IR_LEN, 4, instruction register width (≥2).
- IDCODE_VAL, 32'h1000_563D, value captured by IDCODE (bit0 must be 1).
- IDCODE_INSTR, 4'h1, IDCODE opcode; also the value the IR resets to.
- BYPASS_INSTR, 4'hF, BYPASS opcode (all ones).
- SYNC_STAGES, 2, input synchroniser depth (≥1).

Ports:
- sys_clk  in  1  sole clock.
- sys_rst_n  in  1  asynchronous active-low reset.
- tck  in  1  JTAG clock, sampled as data.
- tms  in  1  mode select.
- tdi  in  1  serial data in.
- tdo  out  1  serial data out.
- tap_state  out  4  current TAP state, IEEE encoding.
- ir_out  out  IR_LEN  active (updated) instruction.
- tlr_active  out  1  high while in Test-Logic-Reset.

Behaviour:
- Reset (async, sys_rst_n low): tap_state=TLR (4'hF), ir_out=IDCODE_INSTR, shift regs=0, tdo=0, tlr_active=1, synchroniser and edge flops=0.
- tck/tms/tdi each pass through SYNC_STAGES flops. A tck_d flop holds the last synced tck.
- Rise = synced tck & ~tck_d; fall = ~synced tck & tck_d. Rise and fall are mutually exclusive.
- tms/tdi are taken from the same synchroniser stage as tck. The driver must hold them stable across the tck rise.
- Tck high and low phases shorter than one sys_clk cycle are unsupported and may be lost.
- Latency: an FSM or shift update is visible SYNC_STAGES+1 sys_clk cycles after the tck pin rises. tdo changes SYNC_STAGES+1 cycles after the tck pin falls.
- On rise: FSM advances per tms using the standard 1149.1 transitions. Action depends on the current (pre-transition) state:
  - Capture-IR: ir_shift <= {zeros, 2'b01}.
  - Shift-IR: ir_shift <= {tdi, ir_shift[IR_LEN-1:1]}.
  - Update-IR: ir_out <= ir_shift.
  - Capture-DR: selected DR loaded. IDCODE gets IDCODE_VAL; BYPASS gets 1'b0.
  - Shift-DR: selected DR shifts right, tdi into MSB.
  - Test-Logic-Reset: ir_out <= IDCODE_INSTR.
- Unknown opcodes select BYPASS.
- On fall: in Shift-IR/Shift-DR, tdo <= LSB of the active shift register. In all other states tdo <= 0.
- tdo is registered and holds between falls.
- Five consecutive rises with tms=1 reach TLR from any state.
- tlr_active is combinational from tap_state.
- Reset asserted mid-shift aborts the shift. No partial update of ir_out or the DRs.

Optional Feature:
- Macro: JTAG_TAP_USER_DR_EN.
- When defined, the block adds:
  - parameter USER_INSTR (default 4'h8);
  - ports user_din in 32, user_dout out 32, user_update out 1.
- With USER_INSTR active:
  - Capture-DR loads user_din.
  - Shift-DR shifts a 32-bit register.
  - Update-DR copies it to user_dout and pulses user_update high for exactly one sys_clk cycle.
  - user_dout resets to 0.
- When the macro is undefined, the ports and logic are absent and USER_INSTR decodes as BYPASS.

Decomposition:
- Package jtag_tap_pkg holds:
  - tap_state_e enum, 4-bit IEEE encoding: TLR=F, RTI=C, SEL_DR=7, CAP_DR=6, SH_DR=2, EX1_DR=1, PAUSE_DR=3, EX2_DR=0, UPD_DR=5, SEL_IR=4, CAP_IR=E, SH_IR=A, EX1_IR=9, PAUSE_IR=B, EX2_IR=8, UPD_IR=D;
  - next-state function;
  - default opcode constants.
- One sub-module: jtag_tck_edge, containing the synchronisers, edge detect and aligned tms/tdi.

Test Plan:
- Reset: assert sys_rst_n=0 mid-Shift-DR -> tap_state=4'hF, tdo=0, ir_out=4'h1, tlr_active=1 with no clock.
- TMS reset: from Shift-DR, 5 tck with tms=1 -> tap_state=4'hF, ir_out=4'h1.
- IDCODE: TLR->RTI->SEL_DR->CAP_DR->SH_DR, then 32 tck -> tdo LSB-first = 32'h1000_563D; exits via EX1_DR->UPD_DR.
- IR capture/BYPASS: shift IR with tdi=1111 -> tdo shows 1,0,0,0; after Update-IR, ir_out=4'hF. Shift DR with tdi=1,0,1,1 -> tdo=0,1,0,1 (one-bit delay).
- Timing: vary SYNC_STAGES 1/3; tck high/low 1 sys_clk each -> no lost edges; tdo changes only after synced falls.
- Feature (JTAG_TAP_USER_DR_EN): IR=4'h8, user_din=32'hDEADBEEF, shift in 32'h1234_5678 -> tdo emits DEADBEEF LSB-first; user_dout=32'h1234_5678; user_update high exactly one cycle.
